// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Load/store request and response bundle between the CPU data
//            port (master) and the data memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Word-organised data memory serving the CPU load/store port.
//            One request at a time, byte-lane write strobes, full-word read
//            response, WAIT_CYCLES programmable wait states before the access.
// Options  : DMEM_ERR_CHECK_EN - flag out-of-range addresses and empty-strobe
//            stores through rsp_err instead of wrapping / completing silently.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,   // asynchronous, active-low
  data_mem_responder_if.slave  bus
);

  localparam int         DEPTH         = 2 ** ADDR_WIDTH;
  localparam logic [3:0] c_WAIT_CYCLES = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    w_req_ready;
  logic                    w_accept;
  logic                    w_access;
  logic                    w_err;

  // Ready only in IDLE and never while reset is held low.
  assign w_req_ready   = (state_q == ST_IDLE) && reset;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;

`ifdef DMEM_ERR_CHECK_EN
  logic [31-ADDR_WIDTH-2:0] hi_q;
  logic                     err_q;
  wire                      w_unused_addr = ^bus.req_addr[1:0];

  // An access is rejected when the address lies beyond the memory or a store carries no lanes.
  assign w_err       = (|hi_q) | (we_q & ~(|wstrb_q));
  assign bus.rsp_err = err_q;

  // Error flag: cleared on accept, captured at the access edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      err_q <= 1'b0;
    end else if (w_accept) begin
      hi_q  <= bus.req_addr[31:ADDR_WIDTH+2];
      err_q <= 1'b0;
    end else if (w_access) begin
      err_q <= w_err;
    end
  end
`else
  // Upper address bits are ignored so the address space wraps.
  wire w_unused_addr = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};

  assign w_err       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold response in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && w_req_ready) begin
          w_accept = 1'b1;
          cnt_d    = c_WAIT_CYCLES;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          w_access = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture at accept and read-data capture at the access edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (w_accept) begin
        we_q    <= bus.req_we;
        idx_q   <= bus.req_addr[ADDR_WIDTH+1:2];
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
      end
      if (w_access) begin
        rdata_q <= (we_q || w_err) ? 32'd0 : mem_q[idx_q];
      end
    end
  end

  // Storage array: not reset, written lane by lane at the access edge of a store.
  always_ff @(posedge clk) begin
    if (w_access && we_q && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
